wb_mux: RTL and testbench

Read-data multiplexer for the MIDI router's Wishbone register bus. It maps a 12-bit vector of peripheral status/data inputs into an 8-bit, 256-location read address space. Every location presents the selected value through a single output register. It sits between the peripheral status sources and the bus master's read-data input.

---
 rtl/wb_mux.sv | 65 ++++++
 tb/tb_wb_mux.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wb_mux.sv
// Registered read-data multiplexer for the MIDI router Wishbone register bus.
// Optional build macro WB_MUX_ID_REG_EN adds version/ID constants at 0xFE/0xFF.
module wb_mux #(
    parameter logic [7:0] ID_VALUE      = 8'hA5,
    parameter logic [7:0] VERSION_VALUE = 8'h01
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [7:0]  wb_addr_i,
    input  logic [11:0] wb_dat_i,
    output logic [7:0]  wb_dat_o
);

    logic [7:0]  int_dat_o;
    logic [7:0]  int_dat_d;
    logic [3:0]  pop_cnt;
    logic [3:0]  bit_idx;
    logic [11:0] bit_shift;

`ifndef WB_MUX_ID_REG_EN
    // Parameters are kept in the port list so both builds share one instantiation.
    logic unused_id;
    assign unused_id = ^{ID_VALUE, VERSION_VALUE};
`endif

    always_comb begin
        int_dat_d = 8'h00;
        pop_cnt   = 4'h0;
        for (int i = 0; i < 12; i++) begin
            pop_cnt = pop_cnt + {3'b000, wb_dat_i[i]};
        end
        // Addresses 0x02..0x0D map onto bits 0..11 via the low nibble.
        bit_idx   = wb_addr_i[3:0] - 4'd2;
        bit_shift = wb_dat_i >> bit_idx;

        if (wb_addr_i == 8'h00) begin
            int_dat_d = wb_dat_i[7:0];
        end else if (wb_addr_i == 8'h01) begin
            int_dat_d = {4'h0, wb_dat_i[11:8]};
        end else if (wb_addr_i >= 8'h02 && wb_addr_i <= 8'h0D) begin
            int_dat_d = {7'h00, bit_shift[0]};
        end else if (wb_addr_i == 8'h0E) begin
            int_dat_d = {4'h0, pop_cnt};
        end else if (wb_addr_i == 8'h0F) begin
            int_dat_d = {7'h00, |wb_dat_i};
`ifdef WB_MUX_ID_REG_EN
        end else if (wb_addr_i == 8'hFE) begin
            int_dat_d = VERSION_VALUE;
        end else if (wb_addr_i == 8'hFF) begin
            int_dat_d = ID_VALUE;
`endif
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            int_dat_o <= 8'h00;
        end else begin
            int_dat_o <= int_dat_d;
        end
    end

    assign wb_dat_o = int_dat_o;

endmodule

// File: tb/tb_wb_mux.sv
// Directed bench for wb_mux: scoreboard of expected read data, one-cycle latency.
module tb_wb_mux;

    logic        clk;
    logic        rst_n;
    logic [7:0]  addr;
    logic [11:0] dat;
    logic [7:0]  dout;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    wb_mux dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_addr_i  (addr),
        .wb_dat_i   (dat),
        .wb_dat_o   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode of the register map.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [11:0] d);
        logic [11:0] tmp;
        if (a == 8'h00) return d[7:0];
        if (a == 8'h01) return {4'h0, d[11:8]};
        if (a >= 8'h02 && a <= 8'h0D) begin
            tmp = d >> (a - 8'd2);
            return {7'h00, tmp[0]};
        end
        if (a == 8'h0E) return 8'($countones(d));
        if (a == 8'h0F) return (d != 12'h000) ? 8'h01 : 8'h00;
`ifdef WB_MUX_ID_REG_EN
        if (a == 8'hFE) return 8'h01;
        if (a == 8'hFF) return 8'hA5;
`endif
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
        end
    endtask

    // Drive one read, expect its data one edge later.
    task automatic step(input logic [7:0] a, input logic [11:0] d, input logic [7:0] expv,
                        input string tag);
        logic [7:0] e;
        @(negedge clk);
        addr = a;
        dat  = d;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty observed=%02h", tag, dout);
        end else begin
            e = exp_q.pop_front();
            check(tag, dout, e);
        end
    endtask

    initial begin
        logic [7:0] id_exp;
        logic [7:0] ver_exp;
        checks   = 0;
        failures = 0;
`ifdef WB_MUX_ID_REG_EN
        id_exp  = 8'hA5;
        ver_exp = 8'h01;
`else
        id_exp  = 8'h00;
        ver_exp = 8'h00;
`endif

        // Reset held across edges with full-ones data.
        rst_n = 1'b0;
        addr  = 8'h00;
        dat   = 12'hFFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_release_no_edge", dout, 8'h00);
        step(8'h00, 12'hFFF, 8'hFF, "first_after_reset");

        step(8'h00, 12'hABC, 8'hBC, "byte_lo");
        step(8'h01, 12'hABC, 8'h0A, "nibble_hi");

        step(8'h02, 12'h801, 8'h01, "bit0");
        step(8'h03, 12'h801, 8'h00, "bit1");
        step(8'h0D, 12'h801, 8'h01, "bit11");
        step(8'h0C, 12'h801, 8'h00, "bit10");

        step(8'h0E, 12'hFFF, 8'h0C, "popcnt_full");
        step(8'h0E, 12'h000, 8'h00, "popcnt_zero");
        step(8'h0E, 12'h5A3, 8'h06, "popcnt_mixed");
        step(8'h0F, 12'h000, 8'h00, "any_zero");
        step(8'h0F, 12'h010, 8'h01, "any_set");

        step(8'hFF, 12'hFFF, id_exp,  "id_reg");
        step(8'hFE, 12'hFFF, ver_exp, "version_reg");
        step(8'h80, 12'hFFF, 8'h00,   "unmapped_80");
        step(8'h10, 12'hFFF, 8'h00,   "unmapped_10");

        for (int i = 0; i < 256; i++) begin
            step(8'(i), 12'h801, model(8'(i), 12'h801), "sweep");
        end
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  ra;
            logic [11:0] rd;
            ra = 8'($urandom_range(0, 17));
            rd = 12'($urandom_range(0, 4095));
            step(ra, rd, model(ra, rd), "random");
        end

        // Asynchronous reset between edges.
        step(8'h00, 12'h055, 8'h55, "pre_async");
        rst_n = 1'b0;
        #1;
        check("async_reset", dout, 8'h00);
        @(posedge clk);
        #1;
        check("async_reset_edge", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h01, 12'h3C5, 8'h03, "post_async");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
